// File: rtl/hit_miss_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hit_miss_scoreboard
// Purpose  : On-chip scoreboard for a fixed-latency ray/AABB intersection
//            unit. Each issued stimulus carries a golden hit/miss vector. The
//            vector travels down a LATENCY-deep delay line and is compared
//            with the unit's hit_miss output. Mismatches are counted as
//            Type1 (golden hit, unit miss) or Type2 (golden miss, unit hit).
//            All counters saturate.
// Revision : 1.0 - initial release
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   one-cycle pulse, starts a run from IDLE or DONE
//   in_valid       in   a stimulus is issued to the unit this cycle
//   golden         in   [N_CH] reference hit/miss per lane
//   hit_miss       in   [N_CH] unit output per lane
//   type1_err      out  [CNT_W] lanes with golden=1, hit_miss=0
//   type2_err      out  [CNT_W] lanes with golden=0, hit_miss=1
//   checked        out  [CNT_W] lane comparisons performed
//   busy           out  high in RUN or DRAIN
//   done           out  high in DONE
//   first_err_idx  out  [CNT_W] stimulus index of the first mismatch
//   first_err_vld  out  first_err_idx holds a captured value
//
// Build option:
//   SCOREBOARD_FIRST_ERR_EN - when defined, a stimulus index travels with
//   every delay-line stage and the index of the first mismatching stimulus
//   is captured. When undefined, first_err_idx/first_err_vld tie to 0.
// ============================================================================
module hit_miss_scoreboard #(
    parameter int LATENCY   = 39,
    parameter int N_CH      = 1,
    parameter int CNT_W     = 16,
    parameter int NUM_TESTS = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [N_CH-1:0]  golden,
    input  logic [N_CH-1:0]  hit_miss,
    output logic [CNT_W-1:0] type1_err,
    output logic [CNT_W-1:0] type2_err,
    output logic [CNT_W-1:0] checked,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    localparam int ISS_W = $clog2(NUM_TESTS + 1);
    localparam int DRN_W = $clog2(LATENCY + 1);
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] C_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Sum is formed one bit wider than either operand so overflow is
    // visible before clamping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(C_SAT)) ? C_SAT : s[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [ISS_W-1:0] issue_cnt_q;
    logic [DRN_W-1:0] drain_cnt_q;

    logic w_start_acc;
    logic w_accept;
    logic w_last;

    assign w_start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_accept    = in_valid && (state_q == S_RUN);
    assign w_last      = w_accept && (issue_cnt_q == ISS_W'(NUM_TESTS - 1));

    // DRAIN covers the delay line plus the compare register stage, so the
    // last counter update and the DONE transition land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_start_acc) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        issue_cnt_q <= '0;
                        drain_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                        if (w_last) begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRN_W'(LATENCY)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // ------------------------------------------------------------------
    // Delay line: stage 0 captures the issued stimulus, the tail stage
    // lines up with the unit output LATENCY edges after issue.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] dl_vld_q;
    logic [N_CH-1:0]    dl_gold_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            dl_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_gold_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0]  <= w_accept;
            dl_gold_q[0] <= golden;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_gold_q[i] <= dl_gold_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare stage: registers the per-lane error vectors together with
    // hit_miss sampled on the edge the tail entry is valid.
    // ------------------------------------------------------------------
    logic            cmp_vld_q;
    logic [N_CH-1:0] cmp_t1_q;
    logic [N_CH-1:0] cmp_t2_q;
    logic            w_cmp_en;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            cmp_vld_q <= 1'b0;
            cmp_t1_q  <= '0;
            cmp_t2_q  <= '0;
        end else begin
            cmp_vld_q <= dl_vld_q[LATENCY-1];
            cmp_t1_q  <= dl_gold_q[LATENCY-1] & ~hit_miss;
            cmp_t2_q  <= ~dl_gold_q[LATENCY-1] & hit_miss;
        end
    end

    assign w_cmp_en = cmp_vld_q && ((state_q == S_RUN) || (state_q == S_DRAIN));

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] type1_q, type1_d;
    logic [CNT_W-1:0] type2_q, type2_d;
    logic [CNT_W-1:0] checked_q, checked_d;

    always_comb begin
        type1_d   = type1_q;
        type2_d   = type2_q;
        checked_d = checked_q;
        if (w_start_acc) begin
            type1_d   = '0;
            type2_d   = '0;
            checked_d = '0;
        end else if (w_cmp_en) begin
            type1_d   = sat_add(type1_q, popcount(cmp_t1_q));
            type2_d   = sat_add(type2_q, popcount(cmp_t2_q));
            checked_d = sat_add(checked_q, PC_W'(N_CH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type1_q   <= '0;
            type2_q   <= '0;
            checked_q <= '0;
        end else begin
            type1_q   <= type1_d;
            type2_q   <= type2_d;
            checked_q <= checked_d;
        end
    end

    assign type1_err = type1_q;
    assign type2_err = type2_q;
    assign checked   = checked_q;

    // ------------------------------------------------------------------
    // First-error capture
    // ------------------------------------------------------------------
`ifdef SCOREBOARD_FIRST_ERR_EN
    logic [CNT_W-1:0] dl_idx_q [LATENCY];
    logic [CNT_W-1:0] cmp_idx_q;
    logic [CNT_W-1:0] fe_idx_q;
    logic             fe_vld_q;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_idx_q[i] <= '0;
            end
            cmp_idx_q <= '0;
        end else begin
            dl_idx_q[0] <= CNT_W'(issue_cnt_q);
            for (int i = 1; i < LATENCY; i++) begin
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
            cmp_idx_q <= dl_idx_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            fe_idx_q <= '0;
            fe_vld_q <= 1'b0;
        end else if (w_cmp_en && !fe_vld_q && (|(cmp_t1_q | cmp_t2_q))) begin
            fe_idx_q <= cmp_idx_q;
            fe_vld_q <= 1'b1;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_vld = fe_vld_q;
`else
    assign first_err_idx = '0;
    assign first_err_vld = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/hit_miss_scoreboard.md
# hit_miss_scoreboard

Synthesizable scoreboard for the Ray_AABB intersection datapaths. It checks the `hit_miss` outputs of a fixed-latency ray/box unit against golden high-precision results issued alongside each stimulus. Mismatches are counted as Type1 (golden hit, unit misses) or Type2 (golden miss, unit hits). It sits beside the unit under test on the FPGA, replacing software-side error tallying, and supports multiple parallel lanes and arbitrary pipeline depth.

## Interface
- `LATENCY`, 39: cycles from stimulus issue (`in_valid`) to the matching `hit_miss` being valid; legal range ≥1.
- `N_CH`, 1: number of parallel ray/box lanes checked per cycle.
- `CNT_W`, 16: width of all error and sample counters.
- `NUM_TESTS`, 10000: stimuli (cycles with `in_valid`) per run.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `in_valid` in 1: a stimulus vector is being issued to the unit this cycle.
- `golden` in N_CH: high-precision hit (1) / miss (0) per lane for the issued stimulus.
- `hit_miss` in N_CH: unit output per lane.
- `type1_err` out CNT_W: count of lanes with golden=1, hit_miss=0.
- `type2_err` out CNT_W: count of lanes with golden=0, hit_miss=1.
- `checked` out CNT_W: count of lane comparisons performed.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `first_err_idx` out CNT_W: stimulus index of the first mismatch (see Configuration).
- `first_err_vld` out 1: `first_err_idx` holds a captured value.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE → RUN on `start`. On entry, clear all counters, the issue counter and the delay line.
- RUN: each `in_valid` pushes `{1, golden}` into a LATENCY-deep shift register; cycles without `in_valid` push `{0, x}`. The issue counter increments per `in_valid`. When the NUM_TESTS-th `in_valid` is accepted, go to DRAIN next cycle.
- DRAIN: shift `{0, x}` for exactly LATENCY cycles, then go to DONE.
- `in_valid` is ignored in IDLE, DRAIN and DONE. `start` is ignored in RUN and DRAIN.
- Compare stage: when the delay-line tail valid is 1, evaluate per lane. t1 = golden & ~hit_miss; t2 = ~golden & hit_miss.
  - `type1_err` += popcount(t1).
  - `type2_err` += popcount(t2).
  - `checked` += N_CH.
- Comparisons proceed in RUN and DRAIN.
- All counters saturate at 2^CNT_W−1; adding to a saturated counter leaves it unchanged.
- Reset mid-run: abandon the run, flush the delay line, return to IDLE, zero all outputs.

## Timing
- Reset value of every output is 0.
- Stimulus issued at rising edge t is compared against `hit_miss` sampled at edge t+LATENCY. Counters reflect it after edge t+LATENCY+1.
- `busy` rises the cycle after `start`.
- `done` rises LATENCY+1 cycles after the edge accepting the last `in_valid`, and stays high until `start` or `rst`.
- In the same cycle as `done`, all final counts are stable.
- Back-to-back `in_valid` every cycle is supported at full rate, with no backpressure.

## Configuration
- `SCOREBOARD_FIRST_ERR_EN` defined: on the first compare with any nonzero t1|t2 in a run, latch the issue index of that stimulus (0-based) into `first_err_idx` and set `first_err_vld`. Both hold until the next `start`/`rst`. This requires an index field of CNT_W bits per delay-line stage.
- Undefined: the index storage is omitted, and `first_err_idx` and `first_err_vld` are constant 0.

## Test plan
- N_CH=1, LATENCY=39, NUM_TESTS=16; golden == hit_miss for all → `type1_err`=0, `type2_err`=0, `checked`=16, `done` 40 cycles after last `in_valid`.
- N_CH=4, LATENCY=3; one stimulus with golden=4'b1111, hit_miss=4'b0101 at t+3 → `type1_err`=2, `type2_err`=0, `checked`=4.
- Gapped `in_valid` (every third cycle), LATENCY=5, mismatch injected only on stimulus #7 → one error counted, `first_err_idx`=7 and `first_err_vld`=1 with the macro, 0/0 without.
- CNT_W=4, 20 consecutive Type2 mismatches → `type2_err` saturates at 15, `checked`=15.
- `rst` asserted mid-RUN after 5 stimuli, then `start` and a clean run of NUM_TESTS=8 → counts reflect only the second run, `checked`=8.
- `start` pulsed during DRAIN → ignored; `done` asserts on schedule, counts unchanged.
